// File: rtl/axi4_lite_master_ctrl_if.sv
// -----------------------------------------------------------------------------
// axi4_lite_master_ctrl_if
// AXI4-Lite bus bundle (AW, W, B, AR, R channels) shared by a master and a
// slave.
//   master modport : drives addresses, payload, VALIDs on AW/W/AR and READYs
//                    on B/R.
//   slave  modport : mirror image of the master modport.
// Parameters:
//   AXI_DATA_WIDTH : data bus width (strobe width is AXI_DATA_WIDTH/8).
//   AXI_ADDR_WIDTH : address width.
// -----------------------------------------------------------------------------
interface axi4_lite_master_ctrl_if #(
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned AXI_ADDR_WIDTH = 16
) ();

  // write address channel
  logic [AXI_ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]                  awprot;
  logic                        awvalid;
  logic                        awready;
  // write data channel
  logic [AXI_DATA_WIDTH-1:0]   wdata;
  logic [AXI_DATA_WIDTH/8-1:0] wstrb;
  logic                        wvalid;
  logic                        wready;
  // write response channel
  logic [1:0]                  bresp;
  logic                        bvalid;
  logic                        bready;
  // read address channel
  logic [AXI_ADDR_WIDTH-1:0]   araddr;
  logic [2:0]                  arprot;
  logic                        arvalid;
  logic                        arready;
  // read data channel
  logic [AXI_DATA_WIDTH-1:0]   rdata;
  logic [1:0]                  rresp;
  logic                        rvalid;
  logic                        rready;

  modport master (
    output awaddr, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arprot, arvalid,
    input  arready,
    input  rdata, rresp, rvalid,
    output rready
  );

  modport slave (
    input  awaddr, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arprot, arvalid,
    output arready,
    output rdata, rresp, rvalid,
    input  rready
  );

endinterface : axi4_lite_master_ctrl_if

// File: rtl/axi4_lite_master_ctrl.sv
// -----------------------------------------------------------------------------
// axi4_lite_master_ctrl
// Single-outstanding AXI4-Lite master. A command accepted on the cmd_* port is
// turned into one AXI4-Lite read or write; the captured BRESP/RRESP (and RDATA
// for reads) is presented on the rsp_* port. A response phase that exceeds
// TIMEOUT_CYCLES parks the block in a sticky FAULT state until reset.
// Ports:
//   clk, rst         : clock (rising edge) and synchronous active-high reset.
//   cmd_valid_i/cmd_ready_o, cmd_write_i, cmd_addr_i, cmd_wdata_i,
//   cmd_wstrb_i      : command handshake and payload (wdata/wstrb unused on
//                      reads).
//   rsp_valid_o/rsp_ready_i, rsp_rdata_o, rsp_resp_o
//                    : response handshake; rdata is 0 after a write.
//   err_timeout_o    : sticky response-timeout flag.
//   m_axi            : AXI4-Lite master port.
// -----------------------------------------------------------------------------
module axi4_lite_master_ctrl #(
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned AXI_ADDR_WIDTH = 16,
  parameter logic [2:0]  AXI_PROT       = 3'b000,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  // command port
  input  logic                        cmd_valid_i,
  output logic                        cmd_ready_o,
  input  logic                        cmd_write_i,
  input  logic [AXI_ADDR_WIDTH-1:0]   cmd_addr_i,
  input  logic [AXI_DATA_WIDTH-1:0]   cmd_wdata_i,
  input  logic [AXI_DATA_WIDTH/8-1:0] cmd_wstrb_i,
  // response port
  output logic                        rsp_valid_o,
  input  logic                        rsp_ready_i,
  output logic [AXI_DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic [1:0]                  rsp_resp_o,
  output logic                        err_timeout_o,
  // AXI4-Lite bus
  axi4_lite_master_ctrl_if.master     m_axi
);

  localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;
  // Counter only has to hold 0 .. TIMEOUT_CYCLES-1.
  localparam int unsigned CNT_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit          TMO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_REQ,
    S_WR_RESP,
    S_RD_REQ,
    S_RD_DATA,
    S_RSP,
    S_FAULT
  } state_e;

  state_e                state_q,   state_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q,  wvalid_d;
  logic                  arvalid_q, arvalid_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q,  addr_d;
  logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]     wstrb_q,   wstrb_d;
  logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            resp_q,    resp_d;
  logic                  err_q,     err_d;
  logic [CNT_W-1:0]      cnt_q,     cnt_d;
  logic                  tmo_hit;

  // Limit reached on this cycle; a response handshake in the same cycle wins.
  assign tmo_hit = TMO_EN && (cnt_q == CNT_LAST);

  // ---------------------------------------------------------------------------
  // Next-state and datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    err_d     = err_q;
    cnt_d     = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          addr_d = cmd_addr_i;
          if (cmd_write_i) begin
            wdata_d   = cmd_wdata_i;
            wstrb_d   = cmd_wstrb_i;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = S_WR_REQ;
          end else begin
            arvalid_d = 1'b1;
            state_d   = S_RD_REQ;
          end
        end
      end

      S_WR_REQ: begin
        // AW and W retire independently; move on once neither is pending.
        if (m_axi.awready) awvalid_d = 1'b0;
        if (m_axi.wready)  wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          cnt_d   = '0;
          state_d = S_WR_RESP;
        end
      end

      S_WR_RESP: begin
        if (m_axi.bvalid) begin
          resp_d  = m_axi.bresp;
          rdata_d = '0;
          state_d = S_RSP;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = S_FAULT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_RD_REQ: begin
        if (m_axi.arready) begin
          arvalid_d = 1'b0;
          cnt_d     = '0;
          state_d   = S_RD_DATA;
        end
      end

      S_RD_DATA: begin
        if (m_axi.rvalid) begin
          rdata_d = m_axi.rdata;
          resp_d  = m_axi.rresp;
          state_d = S_RSP;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = S_FAULT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_RSP: begin
        if (rsp_ready_i) state_d = S_IDLE;
      end

      S_FAULT: begin
        // Parked until reset; only reachable from a response state, so no
        // address-phase VALID is ever abandoned here.
        state_d = S_FAULT;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the values of
    // the previous cycle regardless of statement order.
    if (rst) begin
      state_q   <= S_IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      resp_q    <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: all decoded from registers, never from an incoming READY.
  // ---------------------------------------------------------------------------
  assign cmd_ready_o   = (state_q == S_IDLE);
  assign rsp_valid_o   = (state_q == S_RSP);
  assign rsp_rdata_o   = rdata_q;
  assign rsp_resp_o    = resp_q;
  assign err_timeout_o = err_q;

  assign m_axi.awaddr  = addr_q;
  assign m_axi.awprot  = AXI_PROT;
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = wstrb_q;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.bready  = (state_q == S_WR_RESP);
  assign m_axi.araddr  = addr_q;
  assign m_axi.arprot  = AXI_PROT;
  assign m_axi.arvalid = arvalid_q;
  assign m_axi.rready  = (state_q == S_RD_DATA);

endmodule : axi4_lite_master_ctrl

// File: doc/axi4_lite_master_ctrl.md
Name: axi4_lite_master_ctrl

Overview:
Parametrised, synthesizable AXI4-Lite master. Converts single-beat read/write commands from a simple valid/ready command port into AXI4-Lite channel traffic, and returns the response on a valid/ready response port. Replaces the testbench-only bus bundle for sequencer register access from fabric logic. Adds features the bundle lacks: response capture, a response-phase timeout, and a sticky fault state.

Parameters:
AXI_DATA_WIDTH, 32, data bus width (32 or 64); WSTRB width is AXI_DATA_WIDTH/8.
AXI_ADDR_WIDTH, 16, address width.
AXI_PROT, 3'b000, constant value driven on AWPROT and ARPROT.
TIMEOUT_CYCLES, 1024, maximum cycles spent waiting in a response state; 0 disables the timeout.

Ports:
clk  in  1  clock; all logic is on the rising edge.
rst  in  1  synchronous reset, active-high.
cmd_valid/cmd_ready  in/out  1/1  command handshake.
cmd_write  in  1  1 = write, 0 = read.
cmd_addr  in  AXI_ADDR_WIDTH  byte address.
cmd_wdata/cmd_wstrb  in  AXI_DATA_WIDTH/AXI_DATA_WIDTH/8  write payload; ignored on reads.
rsp_valid/rsp_ready  out/in  1/1  response handshake.
rsp_rdata  out  AXI_DATA_WIDTH  read data; 0 after a write.
rsp_resp  out  2  captured BRESP or RRESP.
err_timeout  out  1  sticky timeout flag.
M_AXI_AWADDR/AWPROT/AWVALID out, AWREADY in  write address channel.
M_AXI_WDATA/WSTRB/WVALID out, WREADY in  write data channel.
M_AXI_BRESP/BVALID in, BREADY out  write response channel.
M_AXI_ARADDR/ARPROT/ARVALID out, ARREADY in  read address channel.
M_AXI_RDATA/RRESP/RVALID in, RREADY out  read data channel.

Behaviour:
- Reset: state IDLE. All VALID/READY outputs 0, rsp_valid 0, rsp_rdata 0, rsp_resp 0, err_timeout 0, timeout counter 0. A reset mid-transaction drops all VALIDs the following cycle.
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP, FAULT.
- Outstanding transactions: exactly one.
- cmd_ready = (state == IDLE). A command is accepted when cmd_valid & cmd_ready; addr, data and strb are registered on that edge.
- IDLE -> WR_REQ on a write command: AWVALID and WVALID both rise the next cycle.
  - Each VALID drops independently on its own handshake (VALID & READY at the edge).
  - AW and W may complete in the same cycle or in either order.
  - WR_REQ -> WR_RESP once both handshakes are done. Earliest case: WR_RESP is entered 1 cycle after the VALIDs rise.
- WR_RESP: BREADY = 1. On BVALID, capture BRESP, set rsp_rdata = 0, go to RSP. BREADY deasserts the next cycle.
- IDLE -> RD_REQ on a read command: ARVALID = 1 until ARREADY; then go to RD_DATA.
- RD_DATA: RREADY = 1. On RVALID, capture RDATA and RRESP, go to RSP.
- Protocol rules:
  - A VALID is never deasserted before its handshake.
  - Address, data and strb outputs are stable while their VALID is high.
  - Outputs never depend combinationally on READY.
- RSP: rsp_valid = 1 and rsp_* are held stable until rsp_ready; then go to IDLE.
  - Minimum command-to-next-cmd_ready, with all slaves and rsp_ready always ready: write 4 cycles, read 4 cycles.
- Timeout: the counter runs only in WR_RESP and RD_DATA and clears on state entry.
  - When TIMEOUT_CYCLES != 0 and the count reaches TIMEOUT_CYCLES with no response handshake: BREADY/RREADY drop, err_timeout is set, and the state goes to FAULT.
  - Address phases never time out, so AXI VALID-hold rules are never violated.
- FAULT: cmd_ready = 0 and all AXI outputs are inactive until rst. err_timeout clears only on rst.
- A response handshake in the same cycle the counter reaches its limit counts as success; no timeout occurs.
- SLVERR and DECERR responses are passed through on rsp_resp and are not a fault.

Test Plan:
- Write addr 0x0010, data 0xDEADBEEF, strb 0xF, slave always ready, BRESP=00 -> AW/W each valid for 1 cycle with correct values; rsp_valid with rsp_resp=00, rsp_rdata=0; cmd_ready back 4 cycles after accept.
- Write with AWREADY delayed 3 cycles and WREADY immediate, then the same with the order swapped -> WVALID drops after 1 cycle while AWVALID holds (and vice versa); exactly one B handshake; AWADDR and WDATA stable throughout.
- Read addr 0x0024, ARREADY after 2 cycles, RDATA 0x12345678 with RRESP=10 -> rsp_rdata=0x12345678, rsp_resp=10, err_timeout stays 0.
- rsp_ready held low for 5 cycles -> rsp_* stable and cmd_ready=0 for those cycles; next command accepted only after the RSP handshake.
- TIMEOUT_CYCLES=8, read with RVALID never asserted -> RREADY drops and err_timeout=1 after 8 cycles in RD_DATA; cmd_ready stays 0 until rst; after rst all outputs are at reset values and a new read completes normally.
- Assert rst while in WR_REQ with AWVALID high -> all VALIDs 0 the next cycle, state IDLE, rsp_valid 0.
